// File: rtl/gift_effect_control.sv
// Power-up effect manager: turns one-cycle gift pulses into timed effect flags,
// a saturating shot magazine and request/acknowledge handshakes for ball and drop events.
module gift_effect_control #(
    parameter int DURATION      = 600,
    parameter int HIDE_DURATION = 180,
    parameter int TBIT          = 10,
    parameter int SHOTS         = 8,
    parameter int SBIT          = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            enable,
    input  logic            paddle_size,
    input  logic            paddle_speed,
    input  logic            give_ball,
    input  logic            ball_size,
    input  logic            ball_display,
    input  logic            get_shot,
    input  logic            drop_block,
    input  logic            life_lost,
    input  logic            fire,
    input  logic            ball_ack,
    input  logic            drop_ack,
    output logic            paddle_wide,
    output logic            paddle_fast,
    output logic            ball_big,
    output logic            ball_hidden,
    output logic [SBIT-1:0] shots_left,
    output logic            shot_fire,
    output logic            ball_req,
    output logic            drop_req
);

    localparam int NUM_TIMERS = 4;
    localparam int SHOT_MAX   = (2 ** SBIT) - 1;

    // Timer slots: 0 paddle wide, 1 paddle fast, 2 ball big, 3 ball hidden.
    localparam logic [NUM_TIMERS-1:0][TBIT-1:0] RELOAD = {
        TBIT'(HIDE_DURATION), TBIT'(DURATION), TBIT'(DURATION), TBIT'(DURATION)
    };

    logic [NUM_TIMERS-1:0][TBIT-1:0] timer, timer_next;
    logic [NUM_TIMERS-1:0]           load;
    logic [SBIT-1:0]                 shots_next;
    logic                            fire_next;
    logic [1:0]                      ball_count, ball_count_next;
    logic                            drop_next;
    int                              shot_sum;

    assign load = {ball_display, ball_size, paddle_speed, paddle_size};

    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        timer_next = timer;
        for (int i = 0; i < NUM_TIMERS; i++) begin
            if (life_lost) begin
                timer_next[i] = '0;
            end else if (load[i]) begin
                timer_next[i] = RELOAD[i];
            end else if (enable && timer[i] != '0) begin
                timer_next[i] = timer[i] - 1'b1;
            end
        end
    end

    // Refill is applied before the shot is taken, so get_shot and fire together can fire from empty.
    always_comb begin
        shot_sum  = int'(shots_left) + (get_shot ? SHOTS : 0);
        fire_next = 1'b0;
        if (shot_sum > SHOT_MAX) begin
            shot_sum = SHOT_MAX;
        end
        if (fire && shot_sum != 0) begin
            shot_sum  = shot_sum - 1;
            fire_next = 1'b1;
        end
        shots_next = SBIT'(shot_sum);
        if (life_lost) begin
            shots_next = '0;
            fire_next  = 1'b0;
        end
    end

    always_comb begin
        ball_count_next = ball_count;
        if (life_lost) begin
            ball_count_next = '0;
        end else if (give_ball && !ball_ack) begin
            if (ball_count != 2'd3) begin
                ball_count_next = ball_count + 2'd1;
            end
        end else if (ball_ack && !give_ball) begin
            if (ball_count != 2'd0) begin
                ball_count_next = ball_count - 2'd1;
            end
        end
    end

    // A pending drop survives life_lost; a same-cycle new drop beats the acknowledge.
    always_comb begin
        drop_next = drop_req;
        if (drop_block) begin
            drop_next = 1'b1;
        end else if (drop_ack) begin
            drop_next = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            timer      <= '0;
            shots_left <= '0;
            shot_fire  <= 1'b0;
            ball_count <= '0;
            drop_req   <= 1'b0;
        end else begin
            timer      <= timer_next;
            shots_left <= shots_next;
            shot_fire  <= fire_next;
            ball_count <= ball_count_next;
            drop_req   <= drop_next;
        end
    end

    assign paddle_wide = (timer[0] != '0);
    assign paddle_fast = (timer[1] != '0);
    assign ball_big    = (timer[2] != '0);
    assign ball_hidden = (timer[3] != '0);
    assign ball_req    = (ball_count != 2'd0);

endmodule

// File: tb/tb_gift_effect_control.sv
// Scoreboard bench for gift_effect_control: each stimulus cycle queues its hand-computed
// expected outputs, and a monitor compares them just after the following clock edge.
module tb_gift_effect_control;

    localparam int DUR  = 4;
    localparam int HIDE = 2;
    localparam int SB   = 3;
    localparam int SH   = 3;

    typedef struct packed {
        logic reset;
        logic enable;
        logic paddle_size;
        logic paddle_speed;
        logic give_ball;
        logic ball_size;
        logic ball_display;
        logic get_shot;
        logic drop_block;
        logic life_lost;
        logic fire;
        logic ball_ack;
        logic drop_ack;
    } stim_t;

    typedef struct packed {
        logic          wide;
        logic          fast;
        logic          big;
        logic          hidden;
        logic [SB-1:0] shots;
        logic          fire;
        logic          breq;
        logic          dreq;
    } outs_t;

    typedef struct {
        string name;
        outs_t outs;
    } exp_t;

    logic  clock = 1'b0;
    stim_t s;
    stim_t drive;
    outs_t e;
    outs_t got;
    exp_t  exp_q[$];
    int    tests_run    = 0;
    int    tests_failed = 0;

    always #5 clock = ~clock;

    gift_effect_control #(
        .DURATION(DUR), .HIDE_DURATION(HIDE), .TBIT(4), .SHOTS(SH), .SBIT(SB)
    ) dut (
        .clock(clock),             .reset(drive.reset),
        .enable(drive.enable),     .paddle_size(drive.paddle_size),
        .paddle_speed(drive.paddle_speed), .give_ball(drive.give_ball),
        .ball_size(drive.ball_size),       .ball_display(drive.ball_display),
        .get_shot(drive.get_shot), .drop_block(drive.drop_block),
        .life_lost(drive.life_lost), .fire(drive.fire),
        .ball_ack(drive.ball_ack), .drop_ack(drive.drop_ack),
        .paddle_wide(got.wide),    .paddle_fast(got.fast),
        .ball_big(got.big),        .ball_hidden(got.hidden),
        .shots_left(got.shots),    .shot_fire(got.fire),
        .ball_req(got.breq),       .drop_req(got.dreq)
    );

    task automatic check(input string name, input outs_t actual, input outs_t want);
        tests_run++;
        if (actual !== want) begin
            tests_failed++;
            $display("FAIL %s: got wide/fast/big/hid/shots/fire/breq/dreq=%b required %b",
                     name, actual, want);
        end
    endtask

    // Monitor: the DUT presents a fresh output word after every edge; compare it to the queued expectation.
    initial begin
        exp_t x;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                check(x.name, got, x.outs);
            end
        end
    end

    // One clock of stimulus; e holds the expected outputs after this edge (shot_fire defaults back to 0).
    task automatic step(input string name);
        exp_t x;
        @(negedge clock);
        drive  = s;
        x.name = name;
        x.outs = e;
        exp_q.push_back(x);
        s      = '0;
        e.fire = 1'b0;
        @(posedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running required finished");
        $fatal(1);
    end

    initial begin
        drive = '0;
        s     = '0;
        e     = '0;

        // 1. reset and paddle_wide lifetime
        s.reset = 1'b1; step("reset_a");
        s.reset = 1'b1; step("reset_b");
        step("idle_after_reset");
        s.paddle_size = 1'b1; e.wide = 1'b1; step("paddle_load");
        for (int k = 1; k <= DUR; k++) begin
            step($sformatf("paddle_gap%0d_a", k));
            step($sformatf("paddle_gap%0d_b", k));
            s.enable = 1'b1;
            e.wide   = (k < DUR);
            step($sformatf("paddle_enable%0d", k));
        end
        step("paddle_expired");

        // 2. reload without accumulation; load beats same-cycle enable
        s.ball_size = 1'b1; e.big = 1'b1; step("big_load");
        s.enable = 1'b1; step("big_en1");
        s.enable = 1'b1; step("big_en2");
        s.ball_size = 1'b1; step("big_reload");
        for (int k = 1; k <= DUR; k++) begin
            s.enable = 1'b1;
            e.big    = (k < DUR);
            step($sformatf("big_post_reload_en%0d", k));
        end
        s.ball_display = 1'b1; s.enable = 1'b1; e.hidden = 1'b1; step("hide_load_with_enable");
        s.enable = 1'b1; step("hide_en1");
        s.enable = 1'b1; e.hidden = 1'b0; step("hide_en2");
        s.paddle_speed = 1'b1; e.fast = 1'b1; step("fast_load");
        for (int k = 1; k <= DUR; k++) begin
            s.enable = 1'b1;
            e.fast   = (k < DUR);
            step($sformatf("fast_en%0d", k));
        end

        // 3. shot magazine: saturating refill, drain, empty fire, refill+fire from empty
        s.get_shot = 1'b1; e.shots = 3'd3; step("shot_get1");
        s.get_shot = 1'b1; e.shots = 3'd6; step("shot_get2");
        s.get_shot = 1'b1; e.shots = 3'd7; step("shot_get3_sat");
        for (int k = 1; k <= 8; k++) begin
            s.fire  = 1'b1;
            e.shots = (k < 8) ? SB'(7 - k) : '0;
            e.fire  = (k < 8);
            step($sformatf("fire%0d", k));
        end
        step("fire_idle");
        s.get_shot = 1'b1; s.fire = 1'b1; e.shots = 3'd2; e.fire = 1'b1; step("get_and_fire_empty");
        step("get_and_fire_idle");

        // 4. extra-ball pending counter
        for (int k = 1; k <= 4; k++) begin
            s.give_ball = 1'b1; e.breq = 1'b1;
            step($sformatf("give_ball%0d", k));
        end
        s.give_ball = 1'b1; s.ball_ack = 1'b1; step("give_and_ack");
        s.ball_ack = 1'b1; step("ball_ack1");
        s.ball_ack = 1'b1; step("ball_ack2");
        s.ball_ack = 1'b1; e.breq = 1'b0; step("ball_ack3");
        s.ball_ack = 1'b1; step("ball_ack_at_zero");
        s.give_ball = 1'b1; e.breq = 1'b1; step("give_after_zero_ack");
        s.ball_ack = 1'b1; e.breq = 1'b0; step("ack_no_wrap");

        // 5. block-drop handshake
        s.drop_block = 1'b1; e.dreq = 1'b1; step("drop_set");
        s.drop_block = 1'b1; s.drop_ack = 1'b1; step("drop_and_ack");
        s.drop_ack = 1'b1; e.dreq = 1'b0; step("drop_ack");
        s.drop_block = 1'b1; e.dreq = 1'b1; step("drop_again");
        s.drop_block = 1'b1; step("drop_coalesce");
        s.drop_ack = 1'b1; e.dreq = 1'b0; step("drop_single_ack");

        // 6. life_lost with fire, then reset mid-effect
        s.paddle_size = 1'b1; s.paddle_speed = 1'b1; s.ball_size = 1'b1; s.ball_display = 1'b1;
        s.get_shot = 1'b1; s.give_ball = 1'b1; s.drop_block = 1'b1;
        e = '{wide: 1'b1, fast: 1'b1, big: 1'b1, hidden: 1'b1, shots: 3'd5,
              fire: 1'b0, breq: 1'b1, dreq: 1'b1};
        step("all_active");
        s.life_lost = 1'b1; s.fire = 1'b1;
        e = '0; e.dreq = 1'b1;
        step("life_lost_with_fire");
        step("life_lost_idle");
        s.paddle_size = 1'b1; s.paddle_speed = 1'b1; s.ball_size = 1'b1; s.ball_display = 1'b1;
        s.get_shot = 1'b1; s.give_ball = 1'b1;
        e = '{wide: 1'b1, fast: 1'b1, big: 1'b1, hidden: 1'b1, shots: 3'd3,
              fire: 1'b0, breq: 1'b1, dreq: 1'b1};
        step("rearm");
        s.reset = 1'b1; s.fire = 1'b1; s.give_ball = 1'b1;
        e = '0;
        step("reset_mid_effect");
        step("reset_idle");

        for (int k = 0; k < 5 && exp_q.size() > 0; k++) begin
            @(posedge clock);
            #2;
        end
        if (exp_q.size() > 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL drain: got %0d pending expectations required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
